// File: rtl/seq_shifter_pkg.sv
// Shared types for the sequential shifter: op encodings, FSM states, widths.
package seq_shifter_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AMT_W = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_LSL  = 2'b01,
    OP_LSR  = 2'b10,
    OP_ASR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shifter.sv
// Combinational single-bit shift step; op NONE passes the operand through.
module shifter
  import seq_shifter_pkg::*;
(
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  output logic [WIDTH-1:0] sout
);

  always_comb begin
    sout = in;
    case (op_e'(shift))
      OP_LSL:  sout = {in[WIDTH-2:0], 1'b0};
      OP_LSR:  sout = {1'b0, in[WIDTH-1:1]};
      OP_ASR:  sout = {in[WIDTH-1], in[WIDTH-1:1]};
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter applying one bit step per clock; the abort input exists
// only when SEQ_SHIFTER_ABORT_EN is defined.
module seq_shifter
  import seq_shifter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
`ifdef SEQ_SHIFTER_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] step_w;

  shifter u_step (
    .in    (sout_q),
    .shift (op_q),
    .sout  (step_w)
  );

  always_comb begin
    state_d = state_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sout_d  = in;
          op_d    = op_e'(op);
          cnt_d   = amt;
          state_d = ((amt == '0) || (op_e'(op) == OP_NONE)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef SEQ_SHIFTER_ABORT_EN
        // Abort leaves the partially shifted value in place.
        if (abort) begin
          state_d = IDLE;
        end else
`endif
        begin
          sout_d = step_w;
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sout_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: expected results queued at issue, checked at done.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] in;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic        abort;
  logic [15:0] sout;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] sout;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  seq_shifter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in),
    .op    (op),
    .amt   (amt),
`ifdef SEQ_SHIFTER_ABORT_EN
    .abort (abort),
`endif
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] a, input logic [1:0] o,
                                        input logic [3:0] n);
    case (o)
      2'b01:   return a << n;
      2'b10:   return a >> n;
      2'b11:   return 16'($signed(a) >>> n);
      default: return a;
    endcase
  endfunction

  // Issue one operation, optionally hammering start/in while busy, then check it.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [1:0] o,
                       input logic [3:0] n, input bit disturb);
    exp_t e;
    exp_t got;
    int   cyc = 0;
    int   busy_n = 0;
    int   d0;
    e.sout = model(a, o, n);
    e.lat  = ((n == 4'd0) || (o == 2'b00)) ? 1 : int'(n) + 1;
    sb.push_back(e);
    d0 = done_cnt;
    start = 1'b1; in = a; op = o; amt = n;
    do begin
      tick();
      cyc++;
      if (busy === 1'b1) busy_n++;
      if (disturb && (cyc == 1 || cyc == 2)) begin
        start = 1'b1; in = 16'hFFFF; op = 2'b10; amt = 4'd1;
      end else begin
        start = 1'b0; in = 16'h5A5A; op = 2'b11; amt = 4'd9;
      end
    end while (done !== 1'b1 && cyc < 40);
    got = sb.pop_front();
    chk({tag, "_lat"}, 32'(cyc), 32'(got.lat));
    chk({tag, "_sout"}, 32'(sout), 32'(got.sout));
    chk({tag, "_busy_n"}, 32'(busy_n), 32'(got.lat));
    tick();
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_hold"}, 32'(sout), 32'(got.sout));
    chk({tag, "_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b1; in = 16'hFFFF; op = 2'b01; amt = 4'd3; abort = 1'b0;
    tick(); tick(); tick();
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_flags", {30'd0, busy, done}, 32'd0);
    // first edge out of reset with start high is accepted
    reset = 1'b0;
    do_op("lsl4", 16'h000F, 2'b01, 4'd4, 1'b0);
    do_op("asr15", 16'h8000, 2'b11, 4'd15, 1'b0);
    do_op("lsr3", 16'h000F, 2'b10, 4'd3, 1'b0);
    do_op("amt0", 16'h000F, 2'b10, 4'd0, 1'b0);
    do_op("opnone", 16'h000F, 2'b00, 4'd7, 1'b0);
    do_op("busy_ign", 16'h000F, 2'b01, 4'd4, 1'b1);
    do_op("asr_pos", 16'h4321, 2'b11, 4'd5, 1'b0);
    do_op("lsl15", 16'hFFFF, 2'b01, 4'd15, 1'b0);

    // reset two cycles into an 8-step shift
    d0 = done_cnt;
    start = 1'b1; in = 16'h00FF; op = 2'b01; amt = 4'd8;
    tick(); start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_flags", {30'd0, busy, done}, 32'd0);
    chk("midrst_sout", 32'(sout), 32'd0);
    repeat (10) tick();
    chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
    do_op("post_rst", 16'h0001, 2'b01, 4'd1, 1'b0);

`ifdef SEQ_SHIFTER_ABORT_EN
    d0 = done_cnt;
    start = 1'b1; in = 16'h0001; op = 2'b01; amt = 4'd8;
    tick(); start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sout", 32'(sout), 32'h0008);
    repeat (10) tick();
    chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
    chk("abort_hold", 32'(sout), 32'h0008);
    abort = 1'b1;
    do_op("abort_idle", 16'h0003, 2'b01, 4'd0, 1'b0);
    abort = 1'b0;
`endif

    for (int i = 0; i < 6; i++) begin
      do_op("rand", 16'($urandom), 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
